// File: rtl/regfile_dump_pkg.sv
// Shared constants and state encoding for the register-file dump engine.
// The default widths are also used by the datapath's register file instance.
package regfile_dump_pkg;

  localparam int DEFAULT_WIDTH      = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SEND    = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_dump.sv
// Walks an inclusive, wrapping register address range and streams each
// (address, data) pair out over a valid/ready handshake.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] startAddr,
  input  logic [ADDR_WIDTH-1:0] endAddr,
  output logic [ADDR_WIDTH-1:0] rfReadAddr,
  input  logic [WIDTH-1:0]      rfReadData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [ADDR_WIDTH-1:0] outAddr,
  output logic [WIDTH-1:0]      outData,
  output logic                  outLast,
  output logic                  busy,
  output logic                  done
);

  state_t                state;
  state_t                nextState;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] lastAddr;
  logic [ADDR_WIDTH-1:0] ptrNext;
  logic                  handshake;

  assign ptrNext   = ptr + ADDR_WIDTH'(1);
  assign handshake = outValid && outReady;

  // Read address depends only on state and ptr, never on outReady, so the
  // consumer has no combinational path into the register file.
  always_comb begin
    nextState  = state;
    rfReadAddr = '0;
    case (state)
      IDLE: begin
        if (start) nextState = CAPTURE;
      end
      CAPTURE: begin
        rfReadAddr = ptr;
        nextState  = SEND;
      end
      SEND: begin
        rfReadAddr = ptrNext;
        if (handshake && outLast) nextState = DONE;
      end
      DONE: begin
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      lastAddr <= '0;
      outValid <= 1'b0;
      outAddr  <= '0;
      outData  <= '0;
      outLast  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= nextState;
      busy  <= (nextState != IDLE);
      done  <= (nextState == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            ptr      <= startAddr;
            lastAddr <= endAddr;
          end
        end
        CAPTURE: begin
          outData  <= rfReadData;
          outAddr  <= ptr;
          outLast  <= (ptr == lastAddr);
          outValid <= 1'b1;
        end
        SEND: begin
          // The lookahead read of ptr+1 lets an accepted word be replaced
          // by the next one in the same cycle.
          if (handshake) begin
            if (outLast) begin
              outValid <= 1'b0;
              outLast  <= 1'b0;
            end else begin
              ptr     <= ptrNext;
              outData <= rfReadData;
              outAddr <= ptrNext;
              outLast <= (ptrNext == lastAddr);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a behavioural register file model.
module tb_regfile_dump;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] startAddr;
  logic [AW-1:0] endAddr;
  logic [AW-1:0] rfReadAddr;
  logic [W-1:0]  rfReadData;
  logic          outValid;
  logic          outReady;
  logic [AW-1:0] outAddr;
  logic [W-1:0]  outData;
  logic          outLast;
  logic          busy;
  logic          done;

  logic [W-1:0]  regs [32];
  logic          wrEn;
  logic [AW-1:0] wrAddr;
  logic [W-1:0]  wrData;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] gotAddr [$];
  logic [W-1:0]  gotData [$];
  logic          gotLast [$];
  int            firstCyc;
  int            lastWordCyc;
  int            doneCyc;

  regfile_dump #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .startAddr  (startAddr),
    .endAddr    (endAddr),
    .rfReadAddr (rfReadAddr),
    .rfReadData (rfReadData),
    .outValid   (outValid),
    .outReady   (outReady),
    .outAddr    (outAddr),
    .outData    (outData),
    .outLast    (outLast),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wrEn) regs[wrAddr] <= wrData;
  end

  assign rfReadData = regs[rfReadAddr];

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start, then collects accepted words until done. mode 0: ready
  // held high; mode 1: ready high on odd cycles. wrCyc>=0 schedules one write.
  task automatic runDump(input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                         input int mode, input bit midStart,
                         input int wrCyc, input logic [AW-1:0] wA, input logic [W-1:0] wD);
    bit finished;
    gotAddr.delete();
    gotData.delete();
    gotLast.delete();
    firstCyc    = -1;
    lastWordCyc = -1;
    doneCyc     = -1;
    finished    = 1'b0;
    startAddr   = sa;
    endAddr     = ea;
    start       = 1'b1;
    outReady    = (mode == 0);
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      outReady = (mode == 0) ? 1'b1 : (cyc % 2 == 1);
      wrEn     = (cyc == wrCyc);
      wrAddr   = wA;
      wrData   = wD;
      start    = midStart && (cyc == 10);
      if (start) begin
        startAddr = 5'd20;
        endAddr   = 5'd21;
      end
      if (done) begin
        doneCyc  = cyc;
        finished = 1'b1;
        break;
      end
      if (outValid && outReady) begin
        gotAddr.push_back(outAddr);
        gotData.push_back(outData);
        gotLast.push_back(outLast);
        if (firstCyc < 0) firstCyc = cyc;
        lastWordCyc = cyc;
      end
      tick();
    end
    wrEn     = 1'b0;
    outReady = 1'b0;
    if (!finished) begin
      checkVal("dump_timeout", 0, 1);
    end else begin
      checkVal("done_after_last_word", doneCyc, lastWordCyc + 1);
      checkVal("busy_in_done", busy, 1);
      // A start presented while in DONE must be ignored.
      startAddr = 5'd7;
      endAddr   = 5'd7;
      start     = 1'b1;
      tick();
      start = 1'b0;
      checkVal("idle_busy_low", busy, 0);
      checkVal("idle_done_low", done, 0);
      tick();
      checkVal("start_in_done_ignored", busy, 0);
    end
  endtask

  initial begin : stimulus
    int expA[4];
    int errs;
    bit sawDone;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    reset     = 1'b1;
    start     = 1'b0;
    startAddr = '0;
    endAddr   = '0;
    outReady  = 1'b0;
    wrEn      = 1'b0;
    wrAddr    = '0;
    wrData    = '0;
    tick();
    tick();
    checkVal("rst_outValid", outValid, 0);
    checkVal("rst_outLast", outLast, 0);
    checkVal("rst_busy", busy, 0);
    checkVal("rst_done", done, 0);
    checkVal("rst_outAddr", outAddr, 0);
    checkVal("rst_outData", outData, 0);
    checkVal("rst_rfReadAddr", rfReadAddr, 0);
    reset = 1'b0;
    tick();

    // Two-word dump 8..9 with ready held high.
    regs[8] = 32'hDEADBEEF;
    regs[9] = 32'h12345678;
    runDump(5'd8, 5'd9, 0, 1'b0, -1, '0, '0);
    checkVal("t1_count", gotAddr.size(), 2);
    if (gotAddr.size() == 2) begin
      checkVal("t1_addr0", gotAddr[0], 8);
      checkVal("t1_data0", gotData[0], 32'hDEADBEEF);
      checkVal("t1_last0", gotLast[0], 0);
      checkVal("t1_addr1", gotAddr[1], 9);
      checkVal("t1_data1", gotData[1], 32'h12345678);
      checkVal("t1_last1", gotLast[1], 1);
    end
    checkVal("t1_first_cycle", firstCyc, 1);
    checkVal("t1_done_cycle", doneCyc, 3);

    // Wrapping range 30..1 with rN = N.
    for (int i = 0; i < 32; i++) regs[i] = i;
    runDump(5'd30, 5'd1, 0, 1'b0, -1, '0, '0);
    expA = '{30, 31, 0, 1};
    checkVal("t2_count", gotAddr.size(), 4);
    checkVal("t2_done_cycle", doneCyc, 5);
    for (int i = 0; i < 4; i++) begin
      if (i < gotAddr.size()) begin
        checkVal($sformatf("t2_addr%0d", i), gotAddr[i], expA[i]);
        checkVal($sformatf("t2_data%0d", i), gotData[i], expA[i]);
        checkVal($sformatf("t2_last%0d", i), gotLast[i], (i == 3));
      end
    end

    // Single word 5..5 with four stall cycles.
    startAddr = 5'd5;
    endAddr   = 5'd5;
    start     = 1'b1;
    outReady  = 1'b0;
    tick();
    start = 1'b0;
    checkVal("t3_capture_valid", outValid, 0);
    checkVal("t3_capture_rdaddr", rfReadAddr, 5);
    checkVal("t3_capture_busy", busy, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      checkVal($sformatf("t3_stall%0d_valid", i), outValid, 1);
      checkVal($sformatf("t3_stall%0d_data", i), outData, 5);
      checkVal($sformatf("t3_stall%0d_addr", i), outAddr, 5);
      checkVal($sformatf("t3_stall%0d_last", i), outLast, 1);
      checkVal($sformatf("t3_stall%0d_lookahead", i), rfReadAddr, 6);
      checkVal($sformatf("t3_stall%0d_done", i), done, 0);
      tick();
    end
    outReady = 1'b1;
    checkVal("t3_accept_valid", outValid, 1);
    tick();
    outReady = 1'b0;
    checkVal("t3_done", done, 1);
    checkVal("t3_done_valid", outValid, 0);
    checkVal("t3_done_last", outLast, 0);
    tick();
    checkVal("t3_done_pulse_len", done, 0);
    checkVal("t3_idle_busy", busy, 0);

    // Full range with toggling ready and an ignored mid-dump start.
    runDump(5'd0, 5'd31, 1, 1'b1, -1, '0, '0);
    checkVal("t4_count", gotAddr.size(), 32);
    errs = 0;
    for (int i = 0; i < gotAddr.size(); i++) begin
      if (gotAddr[i] != AW'(i) || gotData[i] != W'(i) || gotLast[i] != (i == 31)) errs++;
    end
    checkVal("t4_sequence_errors", errs, 0);

    // Write to r3 one cycle before, during, and after its capture cycle.
    regs[3] = 32'h3;
    runDump(5'd2, 5'd3, 0, 1'b0, 0, 5'd3, 32'hAAAA0000);
    checkVal("t5_before_count", gotAddr.size(), 2);
    if (gotAddr.size() == 2) checkVal("t5_before_data", gotData[1], 32'hAAAA0000);
    regs[3] = 32'h3;
    runDump(5'd2, 5'd3, 0, 1'b0, 1, 5'd3, 32'hAAAA0000);
    if (gotAddr.size() == 2) checkVal("t5_same_edge_data", gotData[1], 32'h3);
    else checkVal("t5_same_edge_count", gotAddr.size(), 2);
    checkVal("t5_reg_written", regs[3], 32'hAAAA0000);
    regs[3] = 32'h3;
    runDump(5'd2, 5'd3, 0, 1'b0, 2, 5'd3, 32'hAAAA0000);
    if (gotAddr.size() == 2) checkVal("t5_after_data", gotData[1], 32'h3);
    else checkVal("t5_after_count", gotAddr.size(), 2);

    // Reset during the word for address 2, then a fresh 0..0 dump.
    startAddr = 5'd0;
    endAddr   = 5'd5;
    start     = 1'b1;
    outReady  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    checkVal("t6_word2_addr", outAddr, 2);
    checkVal("t6_word2_valid", outValid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkVal("t6_rst_valid", outValid, 0);
    checkVal("t6_rst_busy", busy, 0);
    checkVal("t6_rst_done", done, 0);
    checkVal("t6_rst_rdaddr", rfReadAddr, 0);
    checkVal("t6_rst_outAddr", outAddr, 0);
    sawDone = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) sawDone = 1'b1;
    end
    checkVal("t6_no_done", sawDone, 0);
    outReady = 1'b0;
    regs[0] = 32'h0BADF00D;
    runDump(5'd0, 5'd0, 0, 1'b0, -1, '0, '0);
    checkVal("t6_after_count", gotAddr.size(), 1);
    if (gotAddr.size() == 1) begin
      checkVal("t6_after_addr", gotAddr[0], 0);
      checkVal("t6_after_data", gotData[0], 32'h0BADF00D);
      checkVal("t6_after_last", gotLast[0], 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
